// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the top module and the RAM array.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_W = 4;

    // Minimum width is 1 so that a single-word RAM still has a legal index.
    function automatic int word_idx_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Word-organised RAM: one synchronous byte-lane write port and one combinational read port.
// Contents are not reset.
module dmem_ram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = word_idx_w(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then holds
// a single response (data or error) until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = word_idx_w(DEPTH_WORDS);
    localparam logic [LATENCY_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : LATENCY_W'(LATENCY - 1);

    state_t               state, state_nxt;
    logic [LATENCY_W-1:0] cnt;
    logic                 enter_resp;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // With zero latency the access happens on the acceptance edge itself,
    // before anything has been latched, so the live request is used there.
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic        ram_we;
    logic [31:0] ram_rdata;

    assign acc_we    = (state == IDLE) ? req_we    : we_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state == IDLE) ? req_be    : be_q;
    assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                       ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign ram_we    = enter_resp && acc_we && !acc_err;

    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (acc_be),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            // Read data is sampled before the store lands, so loads see the old word.
            if (enter_resp) begin
                rsp_rdata <= (acc_we || acc_err) ? 32'h0 : ram_rdata;
                rsp_err   <= acc_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=2, one with LATENCY=0.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        req_valid = 0, req_ready, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_z = 0, req_ready_z, req_we_z = 0;
    logic [31:0] req_addr_z = 0, req_wdata_z = 0;
    logic [3:0]  req_be_z = 0;
    logic        rsp_valid_z, rsp_ready_z = 0, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    // Presents one request to dut for the acceptance edge, then scrambles the request
    // inputs and returns the number of edges (acceptance edge = 1) until rsp_valid.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int lat);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFF3;
        req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
        checks++; if (req_ready_z !== 1'b1 || rsp_valid_z !== 1'b0) begin
            errors++; $display("FAIL reset_lat0 got ready=%b valid=%b want 1/0", req_ready_z, rsp_valid_z);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int lat;
        dut.ram.mem[1] = 32'hDEADBEEF;
        rsp_ready = 1'b1;
        req_we = 0; req_addr = 32'h4; req_be = 4'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'h0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_ready_wait got %b want 0", req_ready); end
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", rsp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_ready_resp got %b want 0", req_ready); end
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL load_exit got valid=%b rdata=%h ready=%b want 0/0/1", rsp_valid, rsp_rdata, req_ready);
        end
    endtask

    task automatic test_store();
        int lat;
        dut.ram.mem[2] = 32'h11223344;
        run_req(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL store_rsp got rdata=%h err=%b want 0/0", rsp_rdata, rsp_err);
        end
        finish_rsp();
        checks++; if (dut.ram.mem[2] !== 32'h11BB33DD) begin errors++; $display("FAIL store_mem got %h want 11bb33dd", dut.ram.mem[2]); end
        run_req(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, lat);
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL store_be0_err got %b want 0", rsp_err); end
        finish_rsp();
        run_req(1'b0, 32'h8, 32'h0, 4'b0000, lat);
        checks++; if (rsp_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL store_readback got %h want 11bb33dd", rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_errors();
        int lat;
        run_req(1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, lat);
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL err_misaligned got err=%b rdata=%h want 1/0", rsp_err, rsp_rdata);
        end
        finish_rsp();
        checks++; if (dut.ram.mem[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem_untouched got %h want deadbeef", dut.ram.mem[1]); end
        checks++; if (req_ready !== 1'b1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL err_idle got ready=%b err=%b want 1/0", req_ready, rsp_err);
        end
        run_req(1'b0, 32'd1024, 32'h0, 4'h0, lat);
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL err_range got err=%b rdata=%h want 1/0", rsp_err, rsp_rdata);
        end
        finish_rsp();
        run_req(1'b0, 32'd1020, 32'h0, 4'h0, lat);
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL err_last_word got err=%b want 0", rsp_err); end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        dut.ram.mem[0] = 32'h1;
        rsp_ready = 1'b0;
        run_req(1'b0, 32'h0, 32'h0, 4'h0, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat); end
        req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hFF; req_be = 4'hF; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h err=%b ready=%b want 1/1/0/0",
                                   c, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        req_valid = 1'b0;
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_exit got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        checks++; if (dut.ram.mem[0] !== 32'h1) begin errors++; $display("FAIL bp_ignored_req got mem0=%h want 1", dut.ram.mem[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0A0A0001; vals[1] = 32'h0B0B0002; vals[2] = 32'h0C0C0003; vals[3] = 32'h0D0D0004;
        for (int i = 0; i < 4; i++) dut0.ram.mem[i] = vals[i];
        rsp_ready_z = 1'b1;
        req_we_z = 1'b0; req_valid_z = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr_z = 32'(4 * i);
            @(posedge clk); #1;
            req_addr_z = 32'h0000_0FFC;
            checks++; if (rsp_valid_z !== 1'b1 || rsp_rdata_z !== vals[i] || req_ready_z !== 1'b0) begin
                errors++; $display("FAIL b2b_rsp %0d got valid=%b rdata=%h ready=%b want 1/%h/0",
                                   i, rsp_valid_z, rsp_rdata_z, req_ready_z, vals[i]);
            end
            @(posedge clk); #1;
            checks++; if (rsp_valid_z !== 1'b0 || req_ready_z !== 1'b1) begin
                errors++; $display("FAIL b2b_exit %0d got valid=%b ready=%b want 0/1", i, rsp_valid_z, req_ready_z);
            end
        end
        req_valid_z = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        dut.ram.mem[3] = 32'h12345678;
        rsp_ready = 1'b1;
        req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_wait got ready=%b want 0", req_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                               req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (dut.ram.mem[3] !== 32'h12345678) begin errors++; $display("FAIL rmid_mem got %h want 12345678", dut.ram.mem[3]); end
        @(posedge clk); #1;
        run_req(1'b0, 32'hC, 32'h0, 4'h0, lat);
        checks++; if (lat != 3 || rsp_rdata !== 32'h12345678) begin
            errors++; $display("FAIL rmid_next got lat=%0d rdata=%h want 3/12345678", lat, rsp_rdata);
        end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
